branch_resolve_unit: RTL and testbench

Execute-stage branch/jump resolution unit, parametrised successor to the combinational PC-jump logic. Resolves B-type, JAL and JALR outcomes, checks them against the fetch-stage prediction (direction and target), and emits a registered redirect and BTB update one cycle later. Maintains a speculative-free return-address stack (RAS) updated at resolution, whose top feeds fetch-stage return prediction.

---
 rtl/branch_resolve_unit_if.sv | 30 +++
 rtl/branch_resolve_unit.sv | 92 +++++++++
 tb/tb_branch_resolve_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: execute-stage resolution bus between pipeline and branch_resolve_unit
interface branch_resolve_unit_if #(parameter int XLEN = 32);
    logic            valid_i, stall_i, flush_i;
    logic [XLEN-1:0] pc_i, imm_i, op1_i;
    logic [6:0]      opcode_i;
    logic [2:0]      func3_i;
    logic [4:0]      rd_i, rs1_i;
    logic            lt_i, ltu_i, zero_i;
    logic            pred_taken_i;
    logic [XLEN-1:0] pred_target_i;
    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            btb_upd_o, btb_taken_o;
    logic [XLEN-1:0] btb_pc_o, btb_target_o;
    logic [XLEN-1:0] ras_top_o;
    logic            ras_valid_o;
    logic [31:0]     perf_branches_o, perf_mispredicts_o;
    modport master (
        output valid_i, stall_i, flush_i, pc_i, imm_i, op1_i, opcode_i, func3_i, rd_i, rs1_i,
               lt_i, ltu_i, zero_i, pred_taken_i, pred_target_i,
        input  redirect_o, redirect_pc_o, btb_upd_o, btb_taken_o, btb_pc_o, btb_target_o,
               ras_top_o, ras_valid_o, perf_branches_o, perf_mispredicts_o
    );
    modport slave (
        input  valid_i, stall_i, flush_i, pc_i, imm_i, op1_i, opcode_i, func3_i, rd_i, rs1_i,
               lt_i, ltu_i, zero_i, pred_taken_i, pred_target_i,
        output redirect_o, redirect_pc_o, btb_upd_o, btb_taken_o, btb_pc_o, btb_target_o,
               ras_top_o, ras_valid_o, perf_branches_o, perf_mispredicts_o
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves B/JAL/JALR, registers redirect + BTB update, maintains a return-address stack.
// Define BRU_PERF_EN to build the branch/mispredict counters; otherwise they read 0.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_resolve_unit_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);
    logic            squash_q, ev, is_jal, is_jalr, is_br, is_cf, cond, br_taken, taken, mispred;
    logic            rd_link, rs1_link, push, pop, pop_ok;
    logic [XLEN-1:0] target, link_pc;
    logic [PW-1:0]   sp_q, sp_base;
    logic [PW:0]     cnt_q, cnt_base;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];

    always_comb begin
        ev       = bus.valid_i & ~bus.flush_i & ~squash_q & ~bus.stall_i;
        is_jal   = bus.opcode_i == 7'b1101111;
        is_jalr  = bus.opcode_i == 7'b1100111;
        is_br    = bus.opcode_i == 7'b1100011;
        is_cf    = is_jal | is_jalr | is_br;
        cond     = bus.func3_i[2:1] == 2'b00 ? bus.zero_i : bus.func3_i[2:1] == 2'b10 ? bus.lt_i : bus.ltu_i;
        br_taken = (bus.func3_i[2:1] != 2'b01) & (cond ^ bus.func3_i[0]);
        taken    = is_jal | is_jalr | (is_br & br_taken);
        target   = is_jalr ? (bus.op1_i + bus.imm_i) & ~XLEN'(1) : bus.pc_i + bus.imm_i;
        link_pc  = bus.pc_i + XLEN'(4);
        mispred  = is_cf & ((taken != bus.pred_taken_i) |
                   (taken & bus.pred_taken_i & (target != bus.pred_target_i)));
        rd_link  = (bus.rd_i == 5'd1) | (bus.rd_i == 5'd5);
        rs1_link = (bus.rs1_i == 5'd1) | (bus.rs1_i == 5'd5);
        push     = ev & (is_jal | is_jalr) & rd_link;
        pop      = ev & is_jalr & rs1_link & (~rd_link | (bus.rd_i != bus.rs1_i));
        // a pop on an empty stack is dropped; a following push then lands on the current slot
        pop_ok   = pop & (cnt_q != '0);
        sp_base  = pop_ok ? sp_q - PW'(1) : sp_q;
        cnt_base = pop_ok ? cnt_q - (PW+1)'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.redirect_o    <= 1'b0;
            bus.redirect_pc_o <= '0;
            bus.btb_upd_o     <= 1'b0;
            bus.btb_taken_o   <= 1'b0;
            bus.btb_pc_o      <= '0;
            bus.btb_target_o  <= '0;
            squash_q          <= 1'b0;
            sp_q              <= '0;
            cnt_q             <= '0;
        end else if (!bus.stall_i) begin
            bus.redirect_o <= ev & mispred;
            squash_q       <= ev & mispred;
            bus.btb_upd_o  <= ev & is_cf;
            if (ev & mispred) bus.redirect_pc_o <= taken ? target : link_pc;
            if (ev & is_cf) begin
                bus.btb_pc_o     <= bus.pc_i;
                bus.btb_target_o <= target;
                bus.btb_taken_o  <= taken;
            end
            sp_q  <= push ? sp_base + PW'(1) : sp_base;
            cnt_q <= push ? (cnt_base == FULL ? FULL : cnt_base + (PW+1)'(1)) : cnt_base;
        end
    end

    always_ff @(posedge clk)
        if (push) ras_q[sp_base] <= link_pc;

    assign bus.ras_valid_o = cnt_q != '0;
    assign bus.ras_top_o   = bus.ras_valid_o ? ras_q[sp_q - PW'(1)] : '0;

`ifdef BRU_PERF_EN
    logic [31:0] branches_q, mispredicts_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            if (ev & is_cf) branches_q <= branches_q + 32'd1;
            if (ev & mispred) mispredicts_q <= mispredicts_q + 32'd1;
        end
    end
    assign bus.perf_branches_o    = branches_q;
    assign bus.perf_mispredicts_o = mispredicts_q;
`else
    assign bus.perf_branches_o    = '0;
    assign bus.perf_mispredicts_o = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed table, hand sequences and random stimulus against a queue-based reference model.
module tb_branch_resolve_unit;
    localparam int XLEN = 32;
    localparam int D    = 4;
    localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_ALU = 7'b0110011;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] pc, imm, op1;
        logic        lt, ltu, zero, pt;
        logic [31:0] ptgt;
        logic        red;
        logic [31:0] rpc;
        logic        upd, tk;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(XLEN)) bus ();
    branch_resolve_unit #(.XLEN(XLEN), .RAS_DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic        m_red, m_sq, m_upd, m_tk;
    logic [31:0] m_rpc, m_bpc, m_btgt, m_pb, m_pm;
    logic [31:0] ras [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic ref_taken(input logic [6:0] op, input logic [2:0] f3, input logic lt, ltu, zero);
        if (op == OP_JAL || op == OP_JALR) return 1'b1;
        if (op != OP_BR) return 1'b0;
        case (f3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input logic [6:0] op, input logic [31:0] pc, imm, op1);
        return op == OP_JALR ? (op1 + imm) & 32'hFFFF_FFFE : pc + imm;
    endfunction

    task automatic model_reset();
        {m_red, m_sq, m_upd, m_tk} = '0;
        {m_rpc, m_bpc, m_btgt, m_pb, m_pm} = '0;
        ras.delete();
    endtask

    task automatic model_step();
        logic cf, tk, mis, ev, rdl, rsl;
        logic [31:0] tg;
        if (bus.stall_i) return;
        cf  = bus.opcode_i inside {OP_JAL, OP_JALR, OP_BR};
        tk  = ref_taken(bus.opcode_i, bus.func3_i, bus.lt_i, bus.ltu_i, bus.zero_i);
        tg  = ref_target(bus.opcode_i, bus.pc_i, bus.imm_i, bus.op1_i);
        ev  = bus.valid_i && !bus.flush_i && !m_sq;
        mis = cf && (tk != bus.pred_taken_i || (tk && tg != bus.pred_target_i));
        m_red = ev && mis;
        m_sq  = m_red;
        m_upd = ev && cf;
        if (m_red) m_rpc = tk ? tg : bus.pc_i + 32'd4;
        if (m_upd) begin
            m_bpc  = bus.pc_i;
            m_btgt = tg;
            m_tk   = tk;
            m_pb++;
        end
        if (m_red) m_pm++;
        if (ev && (bus.opcode_i == OP_JAL || bus.opcode_i == OP_JALR)) begin
            rdl = bus.rd_i inside {5'd1, 5'd5};
            rsl = bus.rs1_i inside {5'd1, 5'd5};
            if (bus.opcode_i == OP_JALR && rsl && bus.rd_i != bus.rs1_i && ras.size() > 0) void'(ras.pop_back());
            if (rdl) begin
                ras.push_back(bus.pc_i + 32'd4);
                if (ras.size() > D) void'(ras.pop_front());
            end
        end
    endtask

    task automatic compare_all();
        chk("redirect", {31'd0, bus.redirect_o}, {31'd0, m_red});
        chk("redirect_pc", bus.redirect_pc_o, m_rpc);
        chk("btb_upd", {31'd0, bus.btb_upd_o}, {31'd0, m_upd});
        chk("btb_pc", bus.btb_pc_o, m_bpc);
        chk("btb_target", bus.btb_target_o, m_btgt);
        chk("btb_taken", {31'd0, bus.btb_taken_o}, {31'd0, m_tk});
        chk("ras_valid", {31'd0, bus.ras_valid_o}, ras.size() > 0 ? 32'd1 : 32'd0);
        chk("ras_top", bus.ras_top_o, ras.size() > 0 ? ras[$] : 32'd0);
`ifdef BRU_PERF_EN
        chk("perf_branches", bus.perf_branches_o, m_pb);
        chk("perf_mispredicts", bus.perf_mispredicts_o, m_pm);
`else
        chk("perf_branches", bus.perf_branches_o, 32'd0);
        chk("perf_mispredicts", bus.perf_mispredicts_o, 32'd0);
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic ins(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc, imm, op1,
                       input logic [4:0] rd, rs1, input logic pt, input logic [31:0] ptgt);
        bus.valid_i = 1'b1; bus.stall_i = 1'b0; bus.flush_i = 1'b0;
        bus.opcode_i = op; bus.func3_i = f3; bus.pc_i = pc; bus.imm_i = imm; bus.op1_i = op1;
        bus.rd_i = rd; bus.rs1_i = rs1; bus.pred_taken_i = pt; bus.pred_target_i = ptgt;
        bus.lt_i = 1'b0; bus.ltu_i = 1'b0; bus.zero_i = 1'b0;
    endtask

    initial begin
        vec_t tbl [10];
        logic [4:0] regs [4];
        logic [6:0] op;
        logic [31:0] pc, imm, op1, r;
        int sel;
        regs = '{5'd0, 5'd1, 5'd5, 5'd2};
        tbl[0] = '{OP_BR,   3'd0, 32'h100,      32'h20,       32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    1'b1, 32'h120,  1'b1, 1'b1};
        tbl[1] = '{OP_BR,   3'd1, 32'h200,      32'h10,       32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 32'h210,  1'b1, 32'h204,  1'b1, 1'b0};
        tbl[2] = '{OP_BR,   3'd4, 32'h400,      32'hFFFFFFF0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 32'h3F0,  1'b0, 32'h0,    1'b1, 1'b1};
        tbl[3] = '{OP_BR,   3'd7, 32'h500,      32'h8,        32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 1'b0};
        tbl[4] = '{OP_BR,   3'd2, 32'h600,      32'h8,        32'h0,    1'b1, 1'b1, 1'b1, 1'b1, 32'h608,  1'b1, 32'h604,  1'b1, 1'b0};
        tbl[5] = '{OP_JALR, 3'd0, 32'h700,      32'h4,        32'h1003, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1007, 1'b1, 32'h1006, 1'b1, 1'b1};
        tbl[6] = '{OP_JAL,  3'd0, 32'hFFFFFFF0, 32'h20,       32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h10,   1'b1, 1'b1};
        tbl[7] = '{OP_BR,   3'd5, 32'h800,      32'h100,      32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 32'h900,  1'b0, 32'h0,    1'b1, 1'b1};
        tbl[8] = '{OP_ALU,  3'd0, 32'h900,      32'h0,        32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0};
        tbl[9] = '{OP_BR,   3'd6, 32'hA00,      32'h40,       32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 32'hA44,  1'b1, 32'hA40,  1'b1, 1'b1};

        ins(OP_ALU, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);
        bus.valid_i = 1'b0;
        model_reset();
        #12;
        compare_all();
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            ins(tbl[i].op, tbl[i].f3, tbl[i].pc, tbl[i].imm, tbl[i].op1, 5'd0, 5'd2, tbl[i].pt, tbl[i].ptgt);
            bus.lt_i = tbl[i].lt; bus.ltu_i = tbl[i].ltu; bus.zero_i = tbl[i].zero;
            tick();
            chk($sformatf("vec%0d redirect", i), {31'd0, bus.redirect_o}, {31'd0, tbl[i].red});
            chk($sformatf("vec%0d btb_upd", i), {31'd0, bus.btb_upd_o}, {31'd0, tbl[i].upd});
            if (tbl[i].red) chk($sformatf("vec%0d redirect_pc", i), bus.redirect_pc_o, tbl[i].rpc);
            if (tbl[i].upd) chk($sformatf("vec%0d btb_taken", i), {31'd0, bus.btb_taken_o}, {31'd0, tbl[i].tk});
            bus.valid_i = 1'b0;
            tick();
        end

        // squash of the instruction following a redirect
        ins(OP_BR, 3'd0, 32'h100, 32'h20, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);
        bus.zero_i = 1'b1;
        tick();
        chk("beq redirect_pc", bus.redirect_pc_o, 32'h120);
        ins(OP_BR, 3'd1, 32'h200, 32'h10, 32'h0, 5'd0, 5'd0, 1'b1, 32'h210);
        bus.zero_i = 1'b1;
        tick();
        chk("squashed redirect", {31'd0, bus.redirect_o}, 32'd0);
        chk("squashed btb_upd", {31'd0, bus.btb_upd_o}, 32'd0);
        tick();
        chk("bne redirect_pc", bus.redirect_pc_o, 32'h204);

        // stall holds the pulse
        bus.stall_i = 1'b1;
        tick();
        chk("stall redirect held", {31'd0, bus.redirect_o}, 32'd1);
        bus.stall_i = 1'b0; bus.valid_i = 1'b0;
        tick();
        tick();

        // RAS: call, return, overflow, underflow, replace
        ins(OP_JAL, 3'd0, 32'h300, 32'h40, 32'h0, 5'd1, 5'd0, 1'b1, 32'h340);
        tick();
        chk("jal no redirect", {31'd0, bus.redirect_o}, 32'd0);
        chk("jal ras_top", bus.ras_top_o, 32'h304);
        ins(OP_JALR, 3'd0, 32'h310, 32'h0, 32'h305, 5'd0, 5'd1, 1'b1, 32'h400);
        tick();
        chk("ret redirect_pc", bus.redirect_pc_o, 32'h304);
        chk("ret ras_valid", {31'd0, bus.ras_valid_o}, 32'd0);
        bus.valid_i = 1'b0;
        tick();
        for (int k = 1; k <= 5; k++) begin
            ins(OP_JAL, 3'd0, 32'(k * 16), 32'h100, 32'h0, 5'd1, 5'd0, 1'b1, 32'(k * 16 + 256));
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            if (k < 4) chk($sformatf("pop%0d ras_top", k), bus.ras_top_o, 32'h54 - 32'(k * 16));
            else chk("pop4 ras_valid", {31'd0, bus.ras_valid_o}, 32'd0);
            ins(OP_JALR, 3'd0, 32'h1000, 32'h0, 32'h1000, 5'd0, 5'd5, 1'b1, 32'h1000);
            tick();
        end
        chk("underflow ras_valid", {31'd0, bus.ras_valid_o}, 32'd0);
        ins(OP_JAL, 3'd0, 32'h900, 32'h10, 32'h0, 5'd5, 5'd0, 1'b1, 32'h910);
        tick();
        chk("push after underflow", bus.ras_top_o, 32'h904);
        ins(OP_JALR, 3'd0, 32'hA00, 32'h0, 32'h2000, 5'd1, 5'd5, 1'b1, 32'h2000);
        tick();
        chk("replace ras_top", bus.ras_top_o, 32'hA04);

        // flush suppresses, reset mid-pulse clears asynchronously
        ins(OP_BR, 3'd0, 32'h100, 32'h20, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);
        bus.zero_i = 1'b1; bus.flush_i = 1'b1;
        tick();
        chk("flush redirect", {31'd0, bus.redirect_o}, 32'd0);
        bus.flush_i = 1'b0;
        tick();
        chk("pre-reset redirect", {31'd0, bus.redirect_o}, 32'd1);
        bus.valid_i = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #2 rst_n = 1'b1;
        tick();

        // randomized against the reference model
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 4));
            op  = sel == 0 ? OP_JAL : sel == 1 ? OP_JALR : sel == 4 ? OP_ALU : OP_BR;
            pc  = $urandom & 32'hFFFF_FFFC;
            r   = $urandom;
            imm = {{20{r[11]}}, r[11:0]};
            op1 = $urandom;
            ins(op, 3'($urandom_range(0, 7)), pc, imm, op1, regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
                1'($urandom_range(0, 1)), $urandom_range(0, 1) != 0 ? ref_target(op, pc, imm, op1) : $urandom);
            bus.lt_i = 1'($urandom_range(0, 1)); bus.ltu_i = 1'($urandom_range(0, 1)); bus.zero_i = 1'($urandom_range(0, 1));
            bus.valid_i = $urandom_range(0, 3) != 0;
            bus.stall_i = $urandom_range(0, 7) == 0;
            bus.flush_i = $urandom_range(0, 7) == 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
